mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit -- multi-cycle CPU control FSM.
//
// Sequences each instruction through IF/ID/EXE/MEM/WB states and decodes
// the datapath control strobes combinationally from the current state,
// the opcode and the ALU flags.
//
// Ports
//   CLK        in   clock, all state changes on the rising edge
//   nReset     in   asynchronous active-low reset
//   Op[5:0]    in   opcode from the instruction register
//   Zero, Sign in   ALU result == 0, ALU result bit 31
//   PCWre, IRWre, RegWre                  out  PC / IR / regfile write enables
//   ALUSrcA, ALUSrcB, DBDataSrc, ExtSel   out  datapath mux / extender selects
//   WrRegDSrc  out  1 = DB bus, 0 = PC+4 as register write data
//   InsMemRw   out  instruction memory read (constant 1)
//   mRD, mWR   out  active-low data memory read / write strobes
//   RegDst[1:0] out 00 = $31, 01 = rt, 10 = rd
//   PCSrc[1:0]  out 00 = PC+4, 01 = branch, 10 = jr rs, 11 = jump
//   ALUOp[2:0]  out ALU function
//   State[ST_W-1:0] out current FSM state (also the debug view of the FSM)
module mc_control_unit #(
  parameter int MEM_LAT = 0,  // extra data-memory wait cycles, 0..7
  parameter int ST_W    = 4
) (
  input  logic            CLK,
  input  logic            nReset,
  input  logic [5:0]      Op,
  input  logic            Zero,
  input  logic            Sign,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            DBDataSrc,
  output logic            ExtSel,
  output logic            WrRegDSrc,
  output logic            InsMemRw,
  output logic            mRD,
  output logic            mWR,
  output logic [1:0]      RegDst,
  output logic [1:0]      PCSrc,
  output logic [2:0]      ALUOp,
  output logic [ST_W-1:0] State
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_B  = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;     // MEM wait counter

  // Opcode decode
  logic is_rtype, is_imm, is_alu, is_branch, is_ls, is_jump, is_nop;
  logic is_sll, is_sw, is_lw, br_taken, mem_last;

  always_comb begin
    is_rtype  = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_OR) ||
                (Op == OP_AND) || (Op == OP_SLL);
    is_imm    = (Op == OP_ADDI) || (Op == OP_ORI) || (Op == OP_SLTI);
    is_alu    = is_rtype || is_imm;
    is_branch = (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_BLTZ);
    is_sw     = (Op == OP_SW);
    is_lw     = (Op == OP_LW);
    is_ls     = is_sw || is_lw;
    is_sll    = (Op == OP_SLL);
    is_jump   = (Op == OP_J) || (Op == OP_JR) || (Op == OP_JAL);
    is_nop    = !(is_alu || is_branch || is_ls || is_jump || (Op == OP_HALT));
    br_taken  = ((Op == OP_BEQ)  &&  Zero) ||
                ((Op == OP_BNE)  && !Zero) ||
                ((Op == OP_BLTZ) &&  Sign);
    // Final MEM cycle: the counter has reached the configured latency.
    mem_last  = (cnt_q == 3'(MEM_LAT));
  end

  // State register and wait counter
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IF;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IF:     state_q <= S_ID;
        S_ID: begin
          if (is_jump || is_nop)  state_q <= S_IF;
          else if (Op == OP_HALT) state_q <= S_HALT;
          else if (is_branch)     state_q <= S_EXE_B;
          else if (is_ls)         state_q <= S_EXE_LS;
          else                    state_q <= S_EXE_AL;
        end
        S_EXE_AL: state_q <= S_WB_AL;
        S_WB_AL:  state_q <= S_IF;
        S_EXE_B:  state_q <= S_IF;
        S_EXE_LS: begin
          state_q <= S_MEM;
          cnt_q   <= 3'd0;
        end
        S_MEM: begin
          if (mem_last) state_q <= is_lw ? S_WB_LD : S_IF;
          else          cnt_q   <= cnt_q + 3'd1;
        end
        S_WB_LD:  state_q <= S_IF;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IF;
      endcase
    end
  end

  assign State = ST_W'(state_q);

  // Output decode
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    ExtSel    = 1'b0;
    WrRegDSrc = 1'b0;
    InsMemRw  = 1'b1;
    mRD       = 1'b1;
    mWR       = 1'b1;
    RegDst    = 2'b01;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;

    case (state_q)
      S_IF: IRWre = 1'b1;

      S_ID: begin
        if (Op == OP_J) begin
          PCWre = 1'b1;
          PCSrc = 2'b11;
        end else if (Op == OP_JR) begin
          PCWre = 1'b1;
          PCSrc = 2'b10;
        end else if (Op == OP_JAL) begin
          PCWre  = 1'b1;
          PCSrc  = 2'b11;
          RegWre = 1'b1;   // link: PC+4 into $31
          RegDst = 2'b00;
        end else if (is_nop) begin
          PCWre = 1'b1;
        end
      end

      S_EXE_AL, S_WB_AL: begin
        RegDst  = is_rtype ? 2'b10 : 2'b01;
        ALUSrcA = is_sll;
        ALUSrcB = is_imm;
        ExtSel  = (Op == OP_ADDI) || (Op == OP_SLTI);
        case (Op)
          OP_SUB:          ALUOp = 3'b001;
          OP_SLL:          ALUOp = 3'b010;
          OP_OR, OP_ORI:   ALUOp = 3'b011;
          OP_AND:          ALUOp = 3'b100;
          OP_SLTI:         ALUOp = 3'b101;
          default:         ALUOp = 3'b000;
        endcase
        if (state_q == S_WB_AL) begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          WrRegDSrc = 1'b1;  // ALU result travels over DB, not PC+4
        end
      end

      S_EXE_B: begin
        ALUOp  = 3'b001;
        ExtSel = 1'b1;
        PCWre  = 1'b1;
        PCSrc  = br_taken ? 2'b01 : 2'b00;
      end

      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end

      S_MEM: begin
        if (is_lw) mRD = 1'b0;
        // Store strobe only once the memory latency has elapsed.
        if (is_sw && mem_last) begin
          mWR   = 1'b0;
          PCWre = 1'b1;
        end
      end

      S_WB_LD: begin
        mRD       = 1'b0;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        WrRegDSrc = 1'b1;  // loaded data travels over DB
      end

      default: ;
    endcase
  end

endmodule
